// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Brief    : Shared VGA timing constants and the 12-bit colour type used by
//             the draw pipeline stages.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int HOR_TOTAL  = 1344;
    localparam int VER_PIXELS = 768;
    localparam int VER_TOTAL  = 806;

    typedef logic [11:0] rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_if
//  Brief    : VGA pipeline bundle (counters, syncs, blanks, colour) with an
//             input view and an output view for the draw stages.
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_if;
    import vga_pkg::*;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    rgb_t        rgb;

    modport vga_in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport vga_out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_delay
//  Brief    : Parametrised shift register, WIDTH bits wide and DEPTH stages
//             deep, cleared by an asynchronous active-low reset.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            // First stage captures the live input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage[i] <= '0;
                else        stage[i] <= din;
            end
        end else begin : g_next
            // Later stages shift the previous stage along
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage[i] <= '0;
                else        stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/draw_bg_scroll.sv
`default_nettype none
// ============================================================================
//  Module   : draw_bg_scroll
//  Brief    : Scrollable background layer. Downscales the screen counters,
//             addresses the background ROM, and composes the ROM pixel over
//             an underlay using a transparent key colour.
//             Optional feature macro: BG_SCROLL_EN (per-frame horizontal
//             scrolling; when undefined the x offset is fixed at 0).
//  Revision : 1.0 - initial release
// ============================================================================
module draw_bg_scroll
    import vga_pkg::*;
#(
    parameter int          IMG_W       = 256,
    parameter int          IMG_H       = 192,
    parameter int          SCALE_LOG2  = 2,
    parameter int          ROM_LAT     = 1,
    parameter int          ADDR_W      = 20,
    parameter logic [11:0] KEY_COLOR   = 12'h000,
    parameter logic [11:0] BLANK_COLOR = 12'h000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_if.vga_in                    vga_in,
    output logic [ADDR_W-1:0]        rom_addr,
    input  rgb_t                     rom_data,
    input  logic                     layer_on,
    input  rgb_t                     layer_rgb,
    input  logic [$clog2(IMG_W)-1:0] scroll_step,
    vga_if.vga_out                   vga_out
);

    localparam int OFF_W = $clog2(IMG_W);
    // x must hold sx plus an offset below IMG_W without overflowing
    localparam int XW    = 12;
    // vcount, hcount, vsync, hsync, vblnk, hblnk, in_img
    localparam int TW    = 11 + 11 + 4 + 1;

    logic [10:0]       sx;
    logic [10:0]       sy;
    logic [XW-1:0]     x;
    logic              in_img;
    logic [ADDR_W-1:0] addr_next;

    assign sx     = vga_in.hcount >> SCALE_LOG2;
    assign sy     = vga_in.vcount >> SCALE_LOG2;
    assign in_img = (sy < 11'(IMG_H));

`ifdef BG_SCROLL_EN
    logic [OFF_W-1:0] scroll_off;
    logic             vsync_prev;
    logic [OFF_W:0]   off_sum;
    logic             unused_inputs;

    assign unused_inputs = ^vga_in.rgb;

    // Next offset: both operands are below IMG_W, so one subtract wraps it
    always_comb begin
        off_sum = {1'b0, scroll_off} + {1'b0, scroll_step};
        if (off_sum >= (OFF_W+1)'(IMG_W)) off_sum = off_sum - (OFF_W+1)'(IMG_W);
    end

    // Remember last vsync so a rising edge advances the offset once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            scroll_off <= '0;
        end else begin
            vsync_prev <= vga_in.vsync;
            if (vga_in.vsync && !vsync_prev) scroll_off <= off_sum[OFF_W-1:0];
        end
    end

    // Scrolled image column with a single wrap subtract
    always_comb begin
        x = XW'(sx) + XW'(scroll_off);
        if (x >= XW'(IMG_W)) x = x - XW'(IMG_W);
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{vga_in.rgb, scroll_step};

    // Fixed image column: screen column folded into the image width
    always_comb begin
        x = XW'(sx) % XW'(IMG_W);
    end
`endif

    assign addr_next = in_img ? (ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(x)) : '0;

    // Stage A: register the ROM address one cycle after the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rom_addr <= '0;
        else        rom_addr <= addr_next;
    end

    // Timing plus in_img travel 1+ROM_LAT stages to meet rom_data
    logic [TW-1:0] tim_in;
    logic [TW-1:0] tim_dly;

    assign tim_in = {vga_in.vcount, vga_in.hcount, vga_in.vsync, vga_in.hsync,
                     vga_in.vblnk, vga_in.hblnk, in_img};

    vga_delay #(
        .WIDTH (TW),
        .DEPTH (1 + ROM_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tim_in),
        .dout  (tim_dly)
    );

    logic [10:0] d_vcount;
    logic [10:0] d_hcount;
    logic        d_vsync;
    logic        d_hsync;
    logic        d_vblnk;
    logic        d_hblnk;
    logic        d_in_img;
    rgb_t        rgb_next;

    assign {d_vcount, d_hcount, d_vsync, d_hsync, d_vblnk, d_hblnk, d_in_img} = tim_dly;

    // Compose: blanking wins, then opaque ROM pixel, then underlay
    always_comb begin
        rgb_next = BLANK_COLOR;
        if (d_hblnk || d_vblnk)                   rgb_next = BLANK_COLOR;
        else if (d_in_img && rom_data != KEY_COLOR) rgb_next = rom_data;
        else if (layer_on)                        rgb_next = layer_rgb;
    end

    // Output register carrying aligned timing and the composed colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.vcount <= '0;
            vga_out.hcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.hsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.vcount <= d_vcount;
            vga_out.hcount <= d_hcount;
            vga_out.vsync  <= d_vsync;
            vga_out.hsync  <= d_hsync;
            vga_out.vblnk  <= d_vblnk;
            vga_out.hblnk  <= d_hblnk;
            vga_out.rgb    <= rgb_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_bg_scroll.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_bg_scroll
//  Brief    : Self-checking bench for draw_bg_scroll, two instances with
//             ROM_LAT=1 and ROM_LAT=3 sharing the same stimulus, checked
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_draw_bg_scroll;
    import vga_pkg::*;

    localparam int          IMG_W = 256;
    localparam int          IMG_H = 192;
    localparam int          SCALE = 2;
    localparam logic [11:0] KEY   = 12'h000;
    localparam logic [11:0] BLANK = 12'h000;

    typedef struct packed {
        logic [10:0] v;
        logic [10:0] h;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic        in_img;
        logic [19:0] addr;
        logic        lon;
        logic [11:0] lrgb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] addr1;
    logic [19:0] addr3;
    rgb_t        rd1;
    rgb_t        rd3;
    logic        lon;
    rgb_t        lrgb;
    logic [7:0]  step_in;
    rgb_t        p1 = '0;
    rgb_t        p3 [3] = '{default: '0};

    vga_if vin ();
    vga_if vo1 ();
    vga_if vo3 ();

    always #5 clk = ~clk;

    draw_bg_scroll #(.ROM_LAT(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .vga_in (vin), .rom_addr (addr1), .rom_data (rd1),
        .layer_on (lon), .layer_rgb (lrgb), .scroll_step (step_in), .vga_out (vo1)
    );

    draw_bg_scroll #(.ROM_LAT(3)) dut3 (
        .clk (clk), .rst_n (rst_n), .vga_in (vin), .rom_addr (addr3), .rom_data (rd3),
        .layer_on (lon), .layer_rgb (lrgb), .scroll_step (step_in), .vga_out (vo3)
    );

    // Background image content: every fourth address is transparent
    function automatic rgb_t rom_fn(input logic [19:0] a);
        if (a[1:0] == 2'b00) return KEY;
        return 12'(a * 20'd157 + 20'h0F0);
    endfunction

    // ROM models with one and three cycles of read latency
    always @(posedge clk) begin
        p1    <= rom_fn(addr1);
        p3[0] <= rom_fn(addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd1 = p1;
    assign rd3 = p3[2];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n        = 0;
    int   off      = 0;
    bit   vs_prev  = 1'b0;
    int   cur_step = 0;
    ent_t hist [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model_entry(input logic [10:0] h, input logic [10:0] v,
                                         input logic vs, input logic hs,
                                         input logic vb, input logic hb);
        ent_t e;
        int   sx;
        int   sy;
        int   x;
        sx = int'(h) >> SCALE;
        sy = int'(v) >> SCALE;
`ifdef BG_SCROLL_EN
        x = sx + off;
        if (x >= IMG_W) x = x - IMG_W;
`else
        x = sx % IMG_W;
`endif
        e        = '0;
        e.h      = h;
        e.v      = v;
        e.vs     = vs;
        e.hs     = hs;
        e.vb     = vb;
        e.hb     = hb;
        e.in_img = (sy < IMG_H);
        e.addr   = e.in_img ? 20'(sy * IMG_W + x) : 20'd0;
        return e;
    endfunction

    function automatic rgb_t exp_rgb(input ent_t e, input logic l_on, input rgb_t l_rgb);
        if (e.hb || e.vb) return BLANK;
        if (e.in_img && rom_fn(e.addr) != KEY) return rom_fn(e.addr);
        if (l_on) return l_rgb;
        return BLANK;
    endfunction

    task automatic chk_zero();
        chk("rst_addr1",  32'(addr1), 32'd0);
        chk("rst_addr3",  32'(addr3), 32'd0);
        chk("rst_tim1",   32'({vo1.vcount, vo1.hcount, vo1.vsync, vo1.hsync, vo1.vblnk, vo1.hblnk}), 32'd0);
        chk("rst_tim3",   32'({vo3.vcount, vo3.hcount, vo3.vsync, vo3.hsync, vo3.vblnk, vo3.hblnk}), 32'd0);
        chk("rst_rgb1",   32'(vo1.rgb), 32'd0);
        chk("rst_rgb3",   32'(vo3.rgb), 32'd0);
    endtask

    task automatic check_all();
        ent_t cur;
        ent_t e1;
        ent_t e3;
        if (!rst_n) begin
            chk_zero();
        end else begin
            cur = hist[n & 63];
            e1  = hist[(n - 2) & 63];
            e3  = hist[(n - 4) & 63];
            chk("addr1", 32'(addr1), 32'(cur.addr));
            chk("addr3", 32'(addr3), 32'(cur.addr));
            chk("timing1", 32'({vo1.vcount, vo1.hcount, vo1.vsync, vo1.hsync, vo1.vblnk, vo1.hblnk}),
                           32'({e1.v, e1.h, e1.vs, e1.hs, e1.vb, e1.hb}));
            chk("timing3", 32'({vo3.vcount, vo3.hcount, vo3.vsync, vo3.hsync, vo3.vblnk, vo3.hblnk}),
                           32'({e3.v, e3.h, e3.vs, e3.hs, e3.vb, e3.hb}));
            chk("rgb1", 32'(vo1.rgb), 32'(exp_rgb(e1, cur.lon, cur.lrgb)));
            chk("rgb3", 32'(vo3.rgb), 32'(exp_rgb(e3, cur.lon, cur.lrgb)));
        end
    endtask

    // Apply one cycle of input, advance the model, then check after the edge
    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic vs,
                        input logic hs, input logic vb, input logic hb,
                        input logic l_on, input rgb_t l_rgb, input int st);
        ent_t e;
        vin.hcount = h;
        vin.vcount = v;
        vin.vsync  = vs;
        vin.hsync  = hs;
        vin.vblnk  = vb;
        vin.hblnk  = hb;
        vin.rgb    = 12'($urandom);
        lon        = l_on;
        lrgb       = l_rgb;
        step_in    = 8'(st);
        if (rst_n) begin
            e = model_entry(h, v, vs, hs, vb, hb);
`ifdef BG_SCROLL_EN
            if (vs && !vs_prev) off = (off + st) % IMG_W;
`endif
            vs_prev = vs;
        end else begin
            e = '0;
        end
        e.lon  = l_on;
        e.lrgb = l_rgb;
        hist[(n + 1) & 63] = e;
        @(posedge clk);
        n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_step(input logic vs);
        step(11'($urandom_range(0, 1343)), 11'($urandom_range(0, 805)), vs,
             1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
             1'($urandom), 12'($urandom), cur_step);
    endtask

    task automatic vsync_pulse(input int st);
        step(11'd0, 11'd790, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, st);
        step(11'd0, 11'd790, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, st);
        step(11'd0, 11'd791, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, st);
        step(11'd0, 11'd792, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, st);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) hist[i] = '0;
        rst_n   = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.vsync = 1'b0; vin.hsync = 1'b0;
        vin.vblnk  = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;
        lon = 1'b0; lrgb = '0; step_in = '0;

        // Reset held for several cycles: everything stays at zero
        @(negedge clk);
        for (int i = 0; i < 5; i++) rand_step(1'b0);
        rst_n = 1'b1;

        // Address of a known pixel straight after reset (offset 0)
        step(11'd8, 11'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0);
        chk("addr_8_4", 32'(addr1), 32'd258);
        // Below the image: address forced to 0, underlay shown
        step(11'd100, 11'd800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'hF00, 0);
        chk("addr_below_img", 32'(addr1), 32'd0);
        // Horizontal blank forces blank colour
        step(11'd20, 11'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hF00, 0);
        for (int i = 0; i < 4; i++) rand_step(1'b0);

`ifdef BG_SCROLL_EN
        // Move offset to 250, then check a wrapping column
        vsync_pulse((250 - off + IMG_W) % IMG_W);
        step(11'd40, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0);
        chk("addr_wrap_250", 32'(addr1), 32'd516);
        // Step changed mid-frame must not move the offset until vsync rises
        for (int i = 0; i < 6; i++)
            step(11'd40, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 5);
        chk("addr_hold_midframe", 32'(addr1), 32'd516);
        vsync_pulse(5);
        step(11'd40, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 5);
        chk("addr_after_step5", 32'(addr1), 32'd521);
        // Offset 255 plus step 1 wraps to 0
        vsync_pulse((255 - off + IMG_W) % IMG_W);
        vsync_pulse(1);
        step(11'd8, 11'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1);
        chk("addr_wrap_255", 32'(addr1), 32'd258);
`else
        // Without scrolling the offset never moves
        vsync_pulse(5);
        vsync_pulse(7);
        step(11'd8, 11'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 5);
        chk("addr_no_scroll", 32'(addr1), 32'd258);
`endif

        // Random frames, step changing mid-frame
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 120; c++) begin
                if (c == 60) cur_step = $urandom_range(0, IMG_W - 1);
                rand_step(1'b0);
            end
            vsync_pulse(cur_step);
        end

        // Asynchronous reset mid-line: outputs clear without a clock edge
        #2;
        rst_n   = 1'b0;
        off     = 0;
        vs_prev = 1'b0;
        #1;
        chk_zero();
        for (int i = 0; i < 5; i++) rand_step(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) rand_step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
